// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types for the SPI transmit arbiter: FSM state encoding and counter sizing.
package spi_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_XFER   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int DEF_SS_SETUP     = 16;
  localparam int DEF_SS_HOLD      = 16;
  localparam int DEF_BUSY_TIMEOUT = 255;

  // One counter serves setup, launch timeout and hold, so size it for the largest.
  function automatic int cnt_width(input int setup, input int hold, input int timeout);
    int m;
    m = setup;
    if (hold > m) m = hold;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SS_SETUP, DEF_SS_HOLD, DEF_BUSY_TIMEOUT);

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping at N-1.
module spi_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  int             j;
  logic [IW-1:0]  jj;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o   = 1'b1;
        gnt_o[jj] = 1'b1;
        gnt_idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one spi_master transmit engine between NUM_REQ requesters, one slave select each,
// sequencing SS assert, setup delay, req/busy handshake and hold delay before SS release.
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SS_SETUP     = DEF_SS_SETUP,
  parameter int SS_HOLD      = DEF_SS_HOLD,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                   sysclk_p,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   data_i,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic                   active_o,
  output logic [NUM_REQ-1:0]     spi_ss_n_o,
  output logic                   spi_tx_req_o,
  output logic [7:0]             spi_tx_data_o,
  input  logic                   spi_busy_i,
  output state_e                 dbg_state_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(SS_SETUP, SS_HOLD, BUSY_TIMEOUT);

  localparam logic [CW-1:0] SETUP_LAST   = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(SS_HOLD - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [CW-1:0]        cnt_q;
  logic [7:0]           byte_q;
  logic [NUM_REQ-1:0]   ss_n_q;
  logic                 tx_req_q;
  logic [7:0]           tx_data_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   err_q;
  logic                 active_q;
  logic                 timeout_q;

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic [7:0]           gnt_byte;
  logic                 grant;

  spi_rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .valid_o   (gnt_valid)
  );

  always_comb begin
    gnt_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) gnt_byte = data_i[8*k +: 8];
    end
  end

  // The winner becomes lowest priority on the next arbitration.
  assign ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign grant = !spi_busy_i && gnt_valid;

  // Handshake: spi_tx_req_o is held high with stable spi_tx_data_o until spi_busy_i is
  // sampled high (that sample is the accept); the transfer ends when spi_busy_i is sampled low.
  always_ff @(posedge sysclk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      byte_q    <= '0;
      ss_n_q    <= '1;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            byte_q    <= gnt_byte;
            ss_n_q    <= ~gnt_oh;
            active_q  <= 1'b1;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            tx_req_q  <= 1'b1;
            tx_data_q <= byte_q;
            cnt_q     <= '0;
            state_q   <= ST_LAUNCH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (spi_busy_i) begin
            tx_req_q <= 1'b0;
            state_q  <= ST_XFER;
          end else if (cnt_q == TIMEOUT_LAST) begin
            tx_req_q  <= 1'b0;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_XFER: begin
          if (!spi_busy_i) begin
            cnt_q   <= '0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            ss_n_q <= '1;
            // The low SS bit still identifies the owner on this last cycle.
            if (timeout_q) err_q  <= ~ss_n_q;
            else           done_q <= ~ss_n_q;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_ss_n_o    = ss_n_q;
  assign spi_tx_req_o  = tx_req_q;
  assign spi_tx_data_o = tx_data_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign active_o      = active_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: directed scenarios plus randomized request rounds, checked
// against a round-robin reference model and an expected-transfer queue.
module tb_spi_tx_arbiter;
  import spi_tx_arbiter_pkg::*;

  localparam int NR           = 4;
  localparam int SS_SETUP     = 16;
  localparam int SS_HOLD      = 16;
  localparam int BUSY_TIMEOUT = 255;
  localparam int W            = 11;

  logic              sysclk_p = 1'b0;
  logic              rst_n    = 1'b0;
  logic [NR-1:0]     req_i    = '0;
  logic [8*NR-1:0]   data_i   = '0;
  logic [NR-1:0]     done_o;
  logic [NR-1:0]     err_o;
  logic              active_o;
  logic [NR-1:0]     spi_ss_n_o;
  logic              spi_tx_req_o;
  logic [7:0]        spi_tx_data_o;
  logic              spi_busy_i = 1'b0;
  state_e            dbg_state_o;

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  int last_k = 0;
  logic [W-1:0] exp_q[$];

  spi_tx_arbiter #(
    .NUM_REQ(NR), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .sysclk_p      (sysclk_p),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .data_i        (data_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .active_o      (active_o),
    .spi_ss_n_o    (spi_ss_n_o),
    .spi_tx_req_o  (spi_tx_req_o),
    .spi_tx_data_o (spi_tx_data_o),
    .spi_busy_i    (spi_busy_i),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and watchdog
  always #5 sysclk_p = ~sysclk_p;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int k);
    logic [NR-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Reference model: serve the first requester at or after the pointer, modulo NR.
  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int i = 0; i < NR; i++) begin
      if (m[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  task automatic push_exp(input int k);
    logic [7:0] b;
    b = data_i[8*k +: 8];
    exp_q.push_back({3'(k), b});
    ptr_m = (k + 1) % NR;
  endtask

  task automatic plan();
    int k;
    k = rr_pick(req_i, ptr_m);
    if (k >= 0) push_exp(k);
  endtask

  // Invariant monitor: one SS low at most, tx_req only under SS, never done and err together.
  always @(negedge sysclk_p) begin
    if (rst_n) begin
      chk("ss_at_most_one", 32'($countones(~spi_ss_n_o) <= 1), 1);
      chk("req_under_ss", 32'(!(spi_tx_req_o && spi_ss_n_o == '1)), 1);
      chk("done_err_excl", 32'(done_o & err_o), 0);
    end
  end

  // Driver for one full transfer of the queue head; returns on the done_o cycle.
  task automatic serve(input bit scramble);
    logic [W-1:0]  e;
    logic [NR-1:0] exp_ss;
    int k;
    int n;
    bit ok;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    k = int'(e[10:8]);
    last_k = k;
    exp_ss = ~onehot(k);
    n = 0;
    while (spi_ss_n_o == '1 && n < 400) begin @(negedge sysclk_p); n++; end
    chk("grant_ss", spi_ss_n_o, exp_ss);
    chk("grant_active", active_o, 1);
    if (scramble) begin
      data_i = $urandom;
      req_i  = NR'($urandom);
    end
    n = 0;
    while (spi_tx_req_o !== 1'b1 && n < 1000) begin @(negedge sysclk_p); n++; end
    chk("setup_cycles", n, SS_SETUP);
    chk("tx_data", spi_tx_data_o, e[7:0]);
    chk("ss_at_launch", spi_ss_n_o, exp_ss);
    repeat ($urandom_range(0, 5)) @(negedge sysclk_p);
    chk("req_held", spi_tx_req_o, 1);
    chk("data_held", spi_tx_data_o, e[7:0]);
    spi_busy_i = 1'b1;
    @(negedge sysclk_p);
    chk("req_drop", spi_tx_req_o, 0);
    repeat ($urandom_range(1, 20)) @(negedge sysclk_p);
    spi_busy_i = 1'b0;
    // busy low is first sampled on the next edge; SS_HOLD cycles follow that edge
    n = 0;
    ok = 1'b1;
    while (done_o == '0 && n < 1000) begin
      if (spi_ss_n_o != exp_ss) ok = 1'b0;
      @(negedge sysclk_p);
      n++;
    end
    chk("ss_during_hold", ok, 1);
    chk("hold_cycles", n, SS_HOLD + 1);
    chk("done_pulse", done_o, onehot(k));
    chk("no_err", err_o, 0);
    chk("ss_release", spi_ss_n_o, 4'hF);
    chk("active_clear", active_o, 0);
  endtask

  initial begin
    logic [NR-1:0] m;
    logic [W-1:0]  e;
    int            order[5];
    int            n;
    bit            seen;

    order = '{0, 1, 2, 3, 0};

    // Reset values, during and after reset
    repeat (3) @(negedge sysclk_p);
    chk("rst_ss", spi_ss_n_o, 4'hF);
    chk("rst_tx_req", spi_tx_req_o, 0);
    chk("rst_tx_data", spi_tx_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_state", dbg_state_o, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk_p);
    chk("idle_ss", spi_ss_n_o, 4'hF);

    // Contention: all four held, order 0,1,2,3,0
    data_i = 32'h13121110;
    req_i  = 4'b1111;
    push_exp(order[0]);
    for (int i = 0; i < 5; i++) begin
      serve(1'b0);
      chk("contention_order", last_k, order[i]);
      if (i < 4) push_exp(order[i + 1]);
      else req_i = '0;
    end
    @(negedge sysclk_p);

    // Single request on requester 1
    data_i = $urandom;
    data_i[15:8] = 8'hA5;
    req_i = 4'b0010;
    push_exp(1);
    serve(1'b0);
    req_i = '0;
    @(negedge sysclk_p);

    // Wrap: serve 2, then 1001 must go 3 then 0
    data_i = $urandom;
    req_i = 4'b0100;
    push_exp(2);
    serve(1'b0);
    req_i = '0;
    @(negedge sysclk_p);
    req_i = 4'b1001;
    push_exp(3);
    serve(1'b0);
    req_i = 4'b0001;
    push_exp(0);
    serve(1'b0);
    req_i = '0;
    @(negedge sysclk_p);

    // Busy never rises: timeout on requester 2
    data_i[23:16] = 8'($urandom);
    req_i = 4'b0100;
    push_exp(2);
    e = exp_q.pop_front();
    n = 0;
    while (spi_ss_n_o == '1 && n < 400) begin @(negedge sysclk_p); n++; end
    chk("to_ss", spi_ss_n_o, 4'b1011);
    n = 0;
    while (spi_tx_req_o !== 1'b1 && n < 1000) begin @(negedge sysclk_p); n++; end
    chk("to_setup", n, SS_SETUP);
    chk("to_data", spi_tx_data_o, e[7:0]);
    n = 0;
    while (spi_tx_req_o === 1'b1 && n < 1000) begin @(negedge sysclk_p); n++; end
    chk("to_req_high_cycles", n, BUSY_TIMEOUT);
    n = 0;
    seen = 1'b0;
    while (err_o == '0 && n < 1000) begin
      if (done_o != '0) seen = 1'b1;
      @(negedge sysclk_p);
      n++;
    end
    chk("to_hold_cycles", n, SS_HOLD);
    chk("to_err", err_o, 4'b0100);
    chk("to_no_done", done_o, 0);
    chk("to_no_done_seen", seen, 0);
    chk("to_ss_release", spi_ss_n_o, 4'hF);
    req_i = '0;
    @(negedge sysclk_p);

    // Busy held high in IDLE blocks the grant until it drops
    spi_busy_i = 1'b1;
    data_i[7:0] = 8'($urandom);
    req_i = 4'b0001;
    push_exp(0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge sysclk_p);
      if (spi_ss_n_o != '1) seen = 1'b1;
    end
    chk("busy_blocks_grant", seen, 0);
    spi_busy_i = 1'b0;
    @(negedge sysclk_p);
    chk("grant_after_busy", spi_ss_n_o, 4'b1110);
    serve(1'b0);
    req_i = '0;
    @(negedge sysclk_p);

    // Randomized rounds; req/data scrambled mid-transfer must be ignored
    for (int r = 0; r < 6; r++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      data_i = $urandom;
      req_i = m;
      plan();
      while (m != '0) begin
        serve(1'b1);
        m[last_k] = 1'b0;
        req_i = m;
        if (m != '0) plan();
      end
      chk("rand_queue_drained", exp_q.size(), 0);
      repeat ($urandom_range(1, 4)) @(negedge sysclk_p);
    end

    // Reset during XFER, then restart with the pointer back at 0
    data_i = $urandom;
    req_i = 4'b0001;
    push_exp(0);
    n = 0;
    while (spi_tx_req_o !== 1'b1 && n < 1000) begin @(negedge sysclk_p); n++; end
    spi_busy_i = 1'b1;
    repeat (3) @(negedge sysclk_p);
    chk("pre_rst_state", dbg_state_o, ST_XFER);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ss", spi_ss_n_o, 4'hF);
    chk("arst_tx_req", spi_tx_req_o, 0);
    chk("arst_tx_data", spi_tx_data_o, 0);
    chk("arst_active", active_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_err", err_o, 0);
    exp_q.delete();
    ptr_m = 0;
    spi_busy_i = 1'b0;
    req_i = 4'b0011;
    @(negedge sysclk_p);
    chk("arst_hold_ss", spi_ss_n_o, 4'hF);
    rst_n = 1'b1;
    push_exp(0);
    serve(1'b0);
    chk("post_rst_winner", last_k, 0);
    req_i = 4'b0010;
    push_exp(1);
    serve(1'b0);
    req_i = '0;
    repeat (3) @(negedge sysclk_p);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
Shares one spi_master transmit engine between NUM_REQ independent requesters, each owning one slave-select line. Arbitrates round-robin and latches the winner's byte. Sequences SS assert, setup delay, spi_master req/busy handshake, and hold delay before SS release. Sits between application logic and spi_master; replaces ad-hoc per-design send state machines.

Parameters:
NUM_REQ, 4, number of requesters / slave-select lines (2..8)
SS_SETUP, 16, sysclk_p cycles from SS low to spi_tx_req_o high (>=1)
SS_HOLD, 16, sysclk_p cycles from spi_busy_i fall to SS high (>=1)
BUSY_TIMEOUT, 255, max cycles in LAUNCH waiting for spi_busy_i rise (>=2)

Ports:
sysclk_p  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  NUM_REQ  per-requester transfer request, level; held until done_o/err_o
data_i  in  8*NUM_REQ  per-requester byte; slice k = bits [8k+7:8k]
done_o  out  NUM_REQ  one-cycle pulse on successful completion for requester k
err_o  out  NUM_REQ  one-cycle pulse on timeout for requester k
active_o  out  1  high from grant until return to IDLE
spi_ss_n_o  out  NUM_REQ  slave selects, active-low, at most one low
spi_tx_req_o  out  1  to spi_master spi_tx_req_i
spi_tx_data_o  out  8  to spi_master spi_tx_data_i
spi_busy_i  in  1  from spi_master spi_busy_o

Behaviour:
- Clock sysclk_p; reset rst_n asynchronous, active-low. All state registered.
- Reset values: spi_ss_n_o all 1, spi_tx_req_o 0, spi_tx_data_o 0, done_o 0, err_o 0, active_o 0, state IDLE, RR pointer 0, counters 0.
- States: IDLE, SETUP, LAUNCH, XFER, HOLD.
- IDLE: grant only when spi_busy_i==0 and any req_i set. Winner = first set bit scanning from pointer upward with wrap (NUM_REQ-1 -> 0). At edge N where grant condition is true: latch winner id and data_i slice, drive winner SS low, active_o=1, pointer<=winner+1 (wrap to 0), counter<=0, go SETUP. SS visible low in cycle N+1.
- SETUP: counter increments; when it reaches SS_SETUP-1, go LAUNCH with spi_tx_req_o=1 and spi_tx_data_o=latched byte. spi_tx_req_o rises exactly SS_SETUP cycles after SS falls.
- LAUNCH: hold spi_tx_req_o=1 and data stable until spi_busy_i==1 sampled, then spi_tx_req_o<=0, go XFER. If BUSY_TIMEOUT cycles elapse without busy: spi_tx_req_o<=0, flag error, go HOLD.
- XFER: wait for spi_busy_i==0, then counter<=0, go HOLD. No timeout (spi_master bounds transfer length).
- HOLD: count SS_HOLD cycles; on final cycle drive SS high, pulse done_o[k] (or err_o[k] if flagged, never both), clear active_o, go IDLE. Earliest next grant is the following cycle, so minimum SS-high gap is 1 cycle.
- req_i changes after grant are ignored until done/err; requester must drop or keep req_i after the pulse (keeping it re-requests, served per RR).
- data_i sampled only at grant; later changes have no effect.
- Simultaneous requests: strict round-robin; after serving k, k has lowest priority. Single persistent requester is re-served back to back.
- spi_busy_i high in IDLE (external use): no grant until it drops.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); SS releases regardless of spi_master state; no done/err pulse.
- Invariant: at most one spi_ss_n_o bit low; spi_tx_req_o high only while that SS is low.

Decomposition:
- Shared package: state encoding constants (IDLE..HOLD), counter width localparam (clog2 of max(SS_SETUP, SS_HOLD, BUSY_TIMEOUT)+1).
- One sub-module natural: spi_rr_arbiter (combinational round-robin pick: req vector + pointer -> one-hot grant + valid), reusable for other shared buses.

Test Plan:
- Single request: req_i=4'b0010, data 8'hA5 -> spi_ss_n_o=4'b1101 one cycle after grant, spi_tx_req_o high 16 cycles later, spi_tx_data_o=8'hA5, done_o[1] pulse 16 cycles after busy falls, same cycle SS all high.
- Contention: req_i=4'b1111 held, data k=8'h10+k -> service order 0,1,2,3,0; each done_o once per transfer, never two SS low.
- Wrap: pointer at 3 after serving 2, req_i=4'b1001 -> 3 served first, then 0.
- Timeout: stub spi_busy_i stuck 0, req_i[2] -> spi_tx_req_o high exactly 255 cycles, then err_o[2] pulse after SS_HOLD, done_o stays 0.
- Busy held externally high in IDLE with req_i[0] -> no SS assert until busy drops; grant the next edge after drop.
- Reset asserted during XFER -> SS all 1, spi_tx_req_o 0 immediately; after release, pending req_i[0] restarts from SETUP with pointer 0.
